// File: rtl/wm_pkg.sv
// Shared opcodes, instruction field positions and FSM states for the washing
// register machine execution core.
package wm_pkg;

    localparam logic [7:0] op_halt    = 8'h00;
    localparam logic [7:0] op_wait    = 8'h11;
    localparam logic [7:0] op_fill    = 8'h12;
    localparam logic [7:0] op_release = 8'h13;
    localparam logic [7:0] op_forward = 8'h14;
    localparam logic [7:0] op_reverse = 8'h15;
    localparam logic [7:0] op_set     = 8'h21;
    localparam logic [7:0] op_dec     = 8'h22;
    localparam logic [7:0] op_j       = 8'h30;
    localparam logic [7:0] op_jz      = 8'h31;
    localparam logic [7:0] op_jnz     = 8'h32;

    localparam int OP_LSB  = 0;
    localparam int REG_LSB = 8;
    localparam int IMM_LSB = 16;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        EXEC  = 2'd1,
        TIMED = 2'd2
    } state_t;

    function automatic logic op_is_timed(input logic [7:0] op);
        return (op >= op_wait) && (op <= op_reverse);
    endfunction

    function automatic logic op_uses_reg(input logic [7:0] op);
        return (op == op_set) || (op == op_dec) || (op == op_jz) || (op == op_jnz);
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        return (op == op_halt) || op_is_timed(op) || op_uses_reg(op) || (op == op_j);
    endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Down-counter for timed phases: loaded with the phase length, counts tick
// pulses and flags the tick that ends the phase.
module wm_phase_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] value,
    input  logic                 tick,
    output logic                 done
);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

    // A tick coinciding with the load is swallowed, so done cannot fire then.
    assign done = tick && !load && (cnt == CNT_WIDTH'(1));

endmodule

// File: rtl/wm_exec.sv
// Execution core of the washing register machine: fetches from the ROM via pc,
// decodes, runs loop-counter registers and drives the one-hot actuator outputs.
module wm_exec
    import wm_pkg::*;
#(
    parameter int INSTRS_WIDTH = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int NREG         = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int START_PC     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    tick,
    input  logic [INSTRS_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    fill_on,
    output logic                    drain_on,
    output logic                    motor_fwd,
    output logic                    motor_rev,
    output logic                    busy,
    output logic                    err
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    state_t               state;
    logic [CNT_WIDTH-1:0] regs [NREG];

    logic [7:0]            op;
    logic [7:0]            rg;
    logic [CNT_WIDTH-1:0]  imm;
    logic [IDX_W-1:0]      ridx;
    logic [CNT_WIDTH-1:0]  cur;
    logic                  bad;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_tgt;
    logic                  timer_load;
    logic                  timer_tick;
    logic                  timer_done;

    assign op     = instr[OP_LSB +: 8];
    assign rg     = instr[REG_LSB +: 8];
    assign imm    = instr[IMM_LSB +: CNT_WIDTH];
    assign ridx   = rg[IDX_W-1:0];
    assign cur    = regs[ridx];
    assign bad    = !op_known(op) || (op_uses_reg(op) && (int'(rg) >= NREG));
    assign pc_inc = pc + ADDR_WIDTH'(1);
    assign pc_tgt = imm[ADDR_WIDTH-1:0];

    assign timer_load = (state == EXEC) && !abort && !bad && op_is_timed(op) && (imm != '0);
    assign timer_tick = (state == TIMED) && !abort && tick;

    wm_phase_timer #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (timer_load),
        .value(imm),
        .tick (timer_tick),
        .done (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HALT;
            pc        <= '0;
            fill_on   <= 1'b0;
            drain_on  <= 1'b0;
            motor_fwd <= 1'b0;
            motor_rev <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (abort) begin
            state     <= HALT;
            pc        <= '0;
            fill_on   <= 1'b0;
            drain_on  <= 1'b0;
            motor_fwd <= 1'b0;
            motor_rev <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                HALT: begin
                    if (start) begin
                        pc    <= ADDR_WIDTH'(START_PC);
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Faults leave pc on the offending instruction for diagnosis.
                    if (bad) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= HALT;
                    end else if (op_is_timed(op)) begin
                        if (imm == '0) begin
                            pc <= pc_inc;
                        end else begin
                            fill_on   <= (op == op_fill);
                            drain_on  <= (op == op_release);
                            motor_fwd <= (op == op_forward);
                            motor_rev <= (op == op_reverse);
                            state     <= TIMED;
                        end
                    end else begin
                        case (op)
                            op_halt: begin
                                busy  <= 1'b0;
                                state <= HALT;
                            end
                            op_set: begin
                                regs[ridx] <= imm;
                                pc         <= pc_inc;
                            end
                            op_dec: begin
                                regs[ridx] <= (cur == '0) ? cur : cur - CNT_WIDTH'(1);
                                pc         <= pc_inc;
                            end
                            op_j:    pc <= pc_tgt;
                            op_jz:   pc <= (cur == '0) ? pc_tgt : pc_inc;
                            op_jnz:  pc <= (cur != '0) ? pc_tgt : pc_inc;
                            default: pc <= pc;
                        endcase
                    end
                end
                TIMED: begin
                    if (timer_done) begin
                        fill_on   <= 1'b0;
                        drain_on  <= 1'b0;
                        motor_fwd <= 1'b0;
                        motor_rev <= 1'b0;
                        pc        <= pc_inc;
                        state     <= EXEC;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wm_exec.sv
// Self-checking bench for wm_exec: program-level reference model checked every
// cycle, directed scenarios with literal expectations, and random programs.
module tb_wm_exec;

    localparam int START = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tick = 1'b0;
    logic [31:0] instr;
    logic [7:0]  pc;
    logic        fill_on, drain_on, motor_fwd, motor_rev, busy, err;

    logic [31:0] rom [256];
    assign instr = rom[pc];

    wm_exec #(
        .INSTRS_WIDTH(32), .ADDR_WIDTH(8), .NREG(4), .CNT_WIDTH(16), .START_PC(START)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tick(tick),
        .instr(instr), .pc(pc), .fill_on(fill_on), .drain_on(drain_on),
        .motor_fwd(motor_fwd), .motor_rev(motor_rev), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ins(input int op, input int rg, input int imm);
        logic [15:0] i16;
        logic [7:0]  r8;
        logic [7:0]  o8;
        i16 = imm[15:0];
        r8  = rg[7:0];
        o8  = op[7:0];
        return {i16, r8, o8};
    endfunction

    // Reference model: program-level view of the machine.
    int m_pc = 0, m_halt = 1, m_left = 0, m_kind = 0, m_err = 0;
    int m_r [4] = '{0, 0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_halt = 1; m_left = 0; m_kind = 0; m_err = 0;
            for (int i = 0; i < 4; i++) m_r[i] = 0;
        end else if (abort) begin
            m_halt = 1; m_left = 0; m_pc = 0;
        end else if (m_halt != 0) begin
            if (start) begin
                m_halt = 0; m_pc = START; m_err = 0;
            end
        end else if (m_left > 0) begin
            if (tick) begin
                m_left--;
                if (m_left == 0) m_pc = (m_pc + 1) % 256;
            end
        end else begin
            logic [31:0] w;
            int op, rg, imm;
            w   = rom[m_pc];
            op  = int'(w[7:0]);
            rg  = int'(w[15:8]);
            imm = int'(w[31:16]);
            if (op == 'h00) begin
                m_halt = 1;
            end else if (op >= 'h11 && op <= 'h15) begin
                if (imm == 0) m_pc = (m_pc + 1) % 256;
                else begin m_left = imm; m_kind = op; end
            end else if (op == 'h30) begin
                m_pc = imm % 256;
            end else if (op == 'h21 || op == 'h22 || op == 'h31 || op == 'h32) begin
                if (rg >= 4) begin
                    m_err = 1; m_halt = 1;
                end else if (op == 'h21) begin
                    m_r[rg] = imm; m_pc = (m_pc + 1) % 256;
                end else if (op == 'h22) begin
                    if (m_r[rg] > 0) m_r[rg]--;
                    m_pc = (m_pc + 1) % 256;
                end else if (op == 'h31) begin
                    m_pc = (m_r[rg] == 0) ? imm % 256 : (m_pc + 1) % 256;
                end else begin
                    m_pc = (m_r[rg] != 0) ? imm % 256 : (m_pc + 1) % 256;
                end
            end else begin
                m_err = 1; m_halt = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit ph;
            ph = (m_halt == 0) && (m_left > 0);
            chk("pc", int'(pc), m_pc);
            chk("busy", int'(busy), int'(m_halt == 0));
            chk("err", int'(err), m_err);
            chk("fill_on", int'(fill_on), int'(ph && m_kind == 'h12));
            chk("drain_on", int'(drain_on), int'(ph && m_kind == 'h13));
            chk("motor_fwd", int'(motor_fwd), int'(ph && m_kind == 'h14));
            chk("motor_rev", int'(motor_rev), int'(ph && m_kind == 'h15));
        end
    end

    // Phase log built from DUT outputs: entry = actuator*1000 + ticks seen while high.
    int  phases [$];
    int  pcnt [4] = '{0, 0, 0, 0};
    logic [3:0] prev_act = 4'b0;

    always @(negedge clk) begin
        logic [3:0] act;
        act = {motor_rev, motor_fwd, drain_on, fill_on};
        for (int a = 0; a < 4; a++) begin
            if (act[a]) begin
                if (!prev_act[a]) pcnt[a] = 0;
                if (tick) pcnt[a]++;
            end else if (prev_act[a]) begin
                phases.push_back(a * 1000 + pcnt[a]);
            end
        end
        prev_act = act;
    end

    task automatic drive(input bit s, input bit a, input bit t);
        start = s; abort = a; tick = t;
        @(posedge clk);
        #1;
    endtask

    function automatic bit rt();
        return ($urandom_range(0, 2) == 0);
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    endtask

    task automatic run_until_halt(input string nm, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            drive(0, 0, rt());
            n++;
        end
        chk(nm, int'(busy), 0);
    endtask

    initial begin
        clear_rom();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_pc", int'(pc), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err", int'(err), 0);
        chk_en = 1'b1;

        // Reset in the middle of a forward phase, then prove registers were cleared.
        rom[2] = ins('h21, 1, 7);
        rom[3] = ins('h14, 0, 5);
        drive(1, 0, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        drive(0, 0, 1);
        chk("t1_fwd_on", int'(motor_fwd), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_fwd", int'(motor_fwd), 0);
        chk("t1_async_pc", int'(pc), 0);
        chk("t1_async_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_rom();
        rom[2]  = ins('h31, 1, 10);
        rom[10] = ins('h00, 0, 0);
        drive(1, 0, 0);
        run_until_halt("t1_halt", 50);
        chk("t1_r1_zero_pc", int'(pc), 10);

        // fill 3: tick at entry ignored, drop on third tick.
        clear_rom();
        rom[2] = ins('h12, 0, 3);
        drive(1, 0, 0);
        chk("t2_pc_start", int'(pc), 2);
        drive(0, 0, 1);
        chk("t2_fill_on", int'(fill_on), 1);
        drive(0, 0, 1);
        drive(0, 0, 0);
        drive(0, 0, 1);
        chk("t2_fill_still", int'(fill_on), 1);
        drive(0, 0, 1);
        chk("t2_fill_off", int'(fill_on), 0);
        chk("t2_pc3", int'(pc), 3);
        run_until_halt("t2_halt", 20);

        // Counted loop, then saturating dec observed through jz.
        clear_rom();
        rom[2] = ins('h21, 0, 2);
        rom[3] = ins('h14, 0, 1);
        rom[4] = ins('h22, 0, 0);
        rom[5] = ins('h32, 0, 3);
        rom[6] = ins('h22, 0, 0);
        rom[7] = ins('h31, 0, 9);
        phases.delete();
        drive(1, 0, 0);
        run_until_halt("t3_halt", 200);
        chk("t3_nphase", phases.size(), 2);
        chk("t3_sat_pc", int'(pc), 9);

        // Illegal opcode, restart, then bad register index.
        clear_rom();
        rom[2] = ins('h21, 0, 1);
        rom[3] = ins('h21, 1, 1);
        rom[4] = ins('h7F, 0, 0);
        drive(1, 0, 0);
        run_until_halt("t4_halt", 20);
        chk("t4_err", int'(err), 1);
        chk("t4_pc", int'(pc), 4);
        drive(1, 0, 0);
        chk("t4_err_clr", int'(err), 0);
        chk("t4_restart_pc", int'(pc), 2);
        run_until_halt("t4_halt2", 20);
        rom[2] = ins('h22, 4, 0);
        drive(1, 0, 0);
        run_until_halt("t4_halt3", 20);
        chk("t4_badreg_err", int'(err), 1);
        chk("t4_badreg_pc", int'(pc), 2);

        // abort with tick during wait 5; abort beats start in HALT.
        clear_rom();
        rom[2] = ins('h11, 0, 5);
        drive(1, 0, 0);
        drive(0, 0, 0);
        drive(0, 0, 1);
        drive(0, 1, 1);
        chk("t5_pc", int'(pc), 0);
        chk("t5_busy", int'(busy), 0);
        repeat (6) drive(0, 0, 1);
        chk("t5_pc_hold", int'(pc), 0);
        drive(1, 1, 0);
        chk("t5_abort_start", int'(busy), 0);

        // Full wash program from START_PC.
        clear_rom();
        rom[2]  = ins('h12, 0, 4);
        rom[3]  = ins('h21, 1, 2);
        rom[4]  = ins('h14, 0, 3);
        rom[5]  = ins('h15, 0, 3);
        rom[6]  = ins('h22, 1, 0);
        rom[7]  = ins('h32, 1, 4);
        rom[8]  = ins('h13, 0, 2);
        rom[9]  = ins('h11, 0, 0);
        rom[10] = ins('h11, 0, 2);
        rom[11] = ins('h14, 0, 2);
        rom[12] = ins('h13, 0, 3);
        rom[13] = ins('h30, 0, 0);
        phases.delete();
        drive(1, 0, 0);
        run_until_halt("t6_halt", 2000);
        chk("t6_pc", int'(pc), 0);
        begin
            int exp_ph [8] = '{0*1000+4, 2*1000+3, 3*1000+3, 2*1000+3,
                               3*1000+3, 1*1000+2, 2*1000+2, 1*1000+3};
            chk("t6_nphase", phases.size(), 8);
            for (int i = 0; i < 8; i++) begin
                if (i < phases.size()) chk($sformatf("t6_phase%0d", i), phases[i], exp_ph[i]);
            end
        end

        // Random programs with random start/abort/tick, checked by the model each cycle.
        for (int p = 0; p < 20; p++) begin
            int ops [12] = '{'h00, 'h11, 'h12, 'h13, 'h14, 'h15, 'h21, 'h22, 'h30, 'h31, 'h32, 'h7F};
            drive(0, 1, 0);
            clear_rom();
            for (int a = 2; a < 16; a++) begin
                int op, imm;
                op = ops[$urandom_range(0, 11)];
                if (op == 'h30 || op == 'h31 || op == 'h32) imm = $urandom_range(0, 15);
                else imm = $urandom_range(0, 3);
                rom[a] = ins(op, $urandom_range(0, 4), imm);
            end
            drive(1, 0, 0);
            for (int c = 0; c < 150; c++) begin
                drive($urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0, rt());
            end
        end
        drive(0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
